// File: rtl/ad9833_pkg.sv
// Shared AD9833 definitions: word width, SPI driver FSM states, control-word bit
// positions and register address prefixes. Used by ad9833_spi_driver and ad9833_ctrl.
package ad9833_pkg;

  localparam int AD9833_WORD_W = 16;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_SETUP,
    SPI_SHIFT,
    SPI_HOLD,
    SPI_GAP
  } spi_state_e;

  // Control register bit positions
  localparam int CTRL_B28     = 13;
  localparam int CTRL_HLB     = 12;
  localparam int CTRL_FSELECT = 11;
  localparam int CTRL_PSELECT = 10;
  localparam int CTRL_RESET   = 8;
  localparam int CTRL_SLEEP1  = 7;
  localparam int CTRL_SLEEP12 = 6;
  localparam int CTRL_OPBITEN = 5;
  localparam int CTRL_DIV2    = 3;
  localparam int CTRL_MODE    = 1;

  // Register address prefixes (top bits of each 16-bit word)
  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_FREQ0  = 2'b01;
  localparam logic [1:0] ADDR_FREQ1  = 2'b10;
  localparam logic [2:0] ADDR_PHASE0 = 3'b110;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ad9833_sclk_tick.sv
// Half-period timer for the AD9833 SPI driver: one-cycle tick every CLK_DIV cycles
// while enabled; disabling it returns the count to zero.
module ad9833_sclk_tick
  import ad9833_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk_i,
  input  logic rst_n_i,
  input  logic i_en,
  output logic o_tick
);

  localparam int              CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ad9833_spi_driver.sv
// AD9833 3-wire serialiser: one 16-bit word per accepted start, MSB first, SCLK idle high.
// Optional `AD9833_SPI_MONITOR_EN adds last_word_o / frame_cnt_o frame monitor ports.
module ad9833_spi_driver
  import ad9833_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 4
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_pluse_i,
  input  logic [AD9833_WORD_W-1:0] cfg_data_i,
  output logic                     bus_busy_o,
  output logic                     ad9833_fsync_o,
  output logic                     ad9833_sclk_o,
  output logic                     ad9833_sdata_o
`ifdef AD9833_SPI_MONITOR_EN
  ,
  output logic [AD9833_WORD_W-1:0] last_word_o,
  output logic [15:0]              frame_cnt_o
`endif
);

  localparam int            GW       = cnt_width(IDLE_GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);

  spi_state_e               r_state;
  logic [AD9833_WORD_W-2:0] r_shift;
  logic [3:0]               r_bit_cnt;
  logic [GW-1:0]            r_gap_cnt;
  logic                     r_busy;
  logic                     r_fsync;
  logic                     r_sclk;
  logic                     r_sdata;
  logic                     w_tick_en;
  logic                     w_tick;
`ifdef AD9833_SPI_MONITOR_EN
  logic [AD9833_WORD_W-1:0] r_word;
  logic [AD9833_WORD_W-1:0] r_last_word;
  logic [15:0]              r_frame_cnt;
`endif

  assign w_tick_en = (r_state == SPI_SETUP) || (r_state == SPI_SHIFT) || (r_state == SPI_HOLD);

  ad9833_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_tick (
    .sys_clk_i (sys_clk_i),
    .rst_n_i   (rst_n_i),
    .i_en      (w_tick_en),
    .o_tick    (w_tick)
  );

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= SPI_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_busy    <= 1'b0;
      r_fsync   <= 1'b1;
      r_sclk    <= 1'b1;
      r_sdata   <= 1'b0;
`ifdef AD9833_SPI_MONITOR_EN
      r_word      <= '0;
      r_last_word <= '0;
      r_frame_cnt <= '0;
`endif
    end else begin
      case (r_state)
        SPI_IDLE: begin
          if (start_pluse_i) begin
            r_state   <= SPI_SETUP;
            r_shift   <= cfg_data_i[AD9833_WORD_W-2:0];
            r_sdata   <= cfg_data_i[AD9833_WORD_W-1];
            r_busy    <= 1'b1;
            r_fsync   <= 1'b0;
            r_bit_cnt <= '0;
`ifdef AD9833_SPI_MONITOR_EN
            r_word    <= cfg_data_i;
`endif
          end
        end
        SPI_SETUP: begin
          // The SETUP exit is also the falling edge that clocks in bit 15
          if (w_tick) begin
            r_state   <= SPI_SHIFT;
            r_sclk    <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        SPI_SHIFT: begin
          if (w_tick) begin
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else begin
              r_sclk <= 1'b1;
              if (r_bit_cnt == 4'd15) begin
                r_state   <= SPI_HOLD;
                r_sdata   <= 1'b0;
                r_bit_cnt <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_sdata   <= r_shift[AD9833_WORD_W-2];
                r_shift   <= {r_shift[AD9833_WORD_W-3:0], 1'b0};
              end
            end
          end
        end
        SPI_HOLD: begin
          if (w_tick) begin
            r_state   <= SPI_GAP;
            r_fsync   <= 1'b1;
            r_gap_cnt <= '0;
`ifdef AD9833_SPI_MONITOR_EN
            r_last_word <= r_word;
            r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
          end
        end
        SPI_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= SPI_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= SPI_IDLE;
      endcase
    end
  end

  assign bus_busy_o     = r_busy;
  assign ad9833_fsync_o = r_fsync;
  assign ad9833_sclk_o  = r_sclk;
  assign ad9833_sdata_o = r_sdata;
`ifdef AD9833_SPI_MONITOR_EN
  assign last_word_o = r_last_word;
  assign frame_cnt_o = r_frame_cnt;
`endif

endmodule

// File: tb/tb_ad9833_spi_driver.sv
// Bench for ad9833_spi_driver: an AD9833-side receiver feeds a word scoreboard for the
// default instance; a second instance runs with CLK_DIV=1, IDLE_GAP=1.
module tb_ad9833_spi_driver;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] data_a, data_b;
  logic        busy_a, fsync_a, sclk_a, sdata_a;
  logic        busy_b, fsync_b, sclk_b, sdata_b;
`ifdef AD9833_SPI_MONITOR_EN
  logic [15:0] last_word_a, frame_cnt_a, last_word_b, frame_cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  ad9833_spi_driver #(.CLK_DIV(4), .IDLE_GAP(4)) dut_a (
    .sys_clk_i      (clk),
    .rst_n_i        (rst_n),
    .start_pluse_i  (start_a),
    .cfg_data_i     (data_a),
    .bus_busy_o     (busy_a),
    .ad9833_fsync_o (fsync_a),
    .ad9833_sclk_o  (sclk_a),
    .ad9833_sdata_o (sdata_a)
`ifdef AD9833_SPI_MONITOR_EN
    ,
    .last_word_o    (last_word_a),
    .frame_cnt_o    (frame_cnt_a)
`endif
  );

  ad9833_spi_driver #(.CLK_DIV(1), .IDLE_GAP(1)) dut_b (
    .sys_clk_i      (clk),
    .rst_n_i        (rst_n),
    .start_pluse_i  (start_b),
    .cfg_data_i     (data_b),
    .bus_busy_o     (busy_b),
    .ad9833_fsync_o (fsync_b),
    .ad9833_sclk_o  (sclk_b),
    .ad9833_sdata_o (sdata_b)
`ifdef AD9833_SPI_MONITOR_EN
    ,
    .last_word_o    (last_word_b),
    .frame_cnt_o    (frame_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AD9833-side receiver for dut_a: samples sdata on each sclk fall inside a frame
  int          cyc = 0;
  int          busy_falls = 0;
  int          busy_start, fsync_start, first_fall, bits;
  logic        in_frame = 1'b0;
  logic        prev_fsync = 1'b1, prev_sclk = 1'b1, prev_busy = 1'b0;
  logic [15:0] rx, exp_w;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame   = 1'b0;
      bits       = 0;
      prev_fsync = 1'b1;
      prev_sclk  = 1'b1;
      prev_busy  = 1'b0;
    end else begin
      if (!prev_busy && busy_a) busy_start = cyc;
      if (prev_busy && !busy_a) begin
        busy_falls++;
        n_checks++;
        if (cyc - busy_start !== 136) begin
          n_fail++;
          $display("FAIL busy_len: got %0d cycles, want 136", cyc - busy_start);
        end
      end
      if (prev_fsync && !fsync_a) begin
        in_frame    = 1'b1;
        bits        = 0;
        rx          = '0;
        fsync_start = cyc;
        first_fall  = -1;
      end
      if (in_frame && !fsync_a && prev_sclk && !sclk_a) begin
        rx = {rx[14:0], sdata_a};
        if (bits == 0) first_fall = cyc;
        bits++;
      end
      if (in_frame && !prev_fsync && fsync_a) begin
        in_frame = 1'b0;
        n_checks++;
        if (bits !== 16) begin
          n_fail++;
          $display("FAIL bit_count: got %0d samples, want 16", bits);
        end
        n_checks++;
        if (cyc - fsync_start !== 132) begin
          n_fail++;
          $display("FAIL fsync_len: got %0d cycles, want 132", cyc - fsync_start);
        end
        n_checks++;
        if (first_fall - fsync_start !== 4) begin
          n_fail++;
          $display("FAIL first_fall: got E0+%0d, want E0+4", first_fall - fsync_start);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_word: got %h, want none (unexpected frame)", rx);
        end else begin
          exp_w = exp_q.pop_front();
          if (rx !== exp_w) begin
            n_fail++;
            $display("FAIL rx_word: got %h, want %h", rx, exp_w);
          end
        end
      end
      prev_fsync = fsync_a;
      prev_sclk  = sclk_a;
      prev_busy  = busy_a;
    end
  end

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (busy_a && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (busy_a) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, want 0", name, busy_a, t);
    end
  endtask

  // Waits for idle, requests word w, holds start for hold extra cycles, then scrambles data
  task automatic send_word(input logic [15:0] w, input int hold);
    wait_idle("send");
    start_a = 1'b1;
    data_a  = w;
    exp_q.push_back(w);
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL accept: busy=%b, want 1", busy_a);
    end
    repeat (hold) @(negedge clk);
    start_a = 1'b0;
    data_a  = ~w;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_a, fsync_a, sclk_a, sdata_a} !== 4'b0110) begin
      n_fail++;
      $display("FAIL reset_a: busy/fsync/sclk/sdata=%b, want 0110", {busy_a, fsync_a, sclk_a, sdata_a});
    end
    n_checks++;
    if ({busy_b, fsync_b, sclk_b, sdata_b} !== 4'b0110) begin
      n_fail++;
      $display("FAIL reset_b: busy/fsync/sclk/sdata=%b, want 0110", {busy_b, fsync_b, sclk_b, sdata_b});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_a, fsync_a, sclk_a} !== 3'b011) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/fsync/sclk=%b, want 011", {busy_a, fsync_a, sclk_a});
    end
  endtask

  task automatic test_back_to_back();
    int falls0;
    falls0 = busy_falls;
    send_word(16'h2000, 2);
    send_word(16'h7DBC, 2);
    send_word(16'h4001, 1);
    wait_idle("b2b");
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_falls - falls0 !== 3) begin
      n_fail++;
      $display("FAIL b2b_busy_falls: got %0d, want 3", busy_falls - falls0);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_pending: got %0d words outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
`ifdef AD9833_SPI_MONITOR_EN
    n_checks++;
    if (frame_cnt_a !== 16'd3) begin
      n_fail++;
      $display("FAIL mon_cnt_pre: got %0d, want 3", frame_cnt_a);
    end
    n_checks++;
    if (last_word_a !== 16'h4001) begin
      n_fail++;
      $display("FAIL mon_word_pre: got %h, want 4001", last_word_a);
    end
`endif
    wait_idle("abort");
    start_a = 1'b1;
    data_a  = 16'hFFFF;
    @(negedge clk);
    start_a = 1'b0;
    repeat (49) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_a, fsync_a, sclk_a} !== 3'b011) begin
      n_fail++;
      $display("FAIL abort_async: busy/fsync/sclk=%b, want 011", {busy_a, fsync_a, sclk_a});
    end
`ifdef AD9833_SPI_MONITOR_EN
    n_checks++;
    if ({frame_cnt_a, last_word_a} !== 32'h0) begin
      n_fail++;
      $display("FAIL mon_after_reset: cnt=%0d word=%h, want 0 0000", frame_cnt_a, last_word_a);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_word(16'hFFFF, 1);
    wait_idle("abort_resend");
  endtask

  task automatic test_single();
    send_word(16'h2000, 0);
    wait_idle("single");
  endtask

  task automatic test_held_start();
    int t;
    wait_idle("held");
    start_a = 1'b1;
    data_a  = 16'hA5A5;
    exp_q.push_back(16'hA5A5);
    repeat (10) @(negedge clk);
    start_a = 1'b0;
    wait_idle("held_frame");
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL held_no_repeat: busy=%b, want 0", busy_a);
    end
    // Start raised mid-frame and still high when busy falls starts exactly one more frame
    start_a = 1'b1;
    data_a  = 16'h1234;
    @(negedge clk);
    start_a = 1'b0;
    repeat (60) @(negedge clk);
    start_a = 1'b1;
    data_a  = 16'h5A3C;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5A3C);
    t = 0;
    while (busy_a && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL start_at_busy_fall: busy=%b, want 1", busy_a);
    end
    start_a = 1'b0;
    wait_idle("held_second");
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL held_pending: got %0d words outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_fast();
    logic [15:0] rx_b;
    logic        p_sclk;
    int          nbits, busy_cyc, fsync_cyc, toggles;
    rx_b = '0;
    nbits = 0;
    busy_cyc = 0;
    fsync_cyc = 0;
    toggles = 0;
    p_sclk = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    data_b  = 16'h8001;
    @(negedge clk);
    start_b = 1'b0;
    data_b  = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      if (busy_b) busy_cyc++;
      if (!fsync_b) begin
        fsync_cyc++;
        if (sclk_b !== p_sclk) toggles++;
        if (p_sclk && !sclk_b) begin
          rx_b = {rx_b[14:0], sdata_b};
          nbits++;
        end
      end
      p_sclk = sclk_b;
      @(negedge clk);
    end
    n_checks++;
    if (rx_b !== 16'h8001 || nbits !== 16) begin
      n_fail++;
      $display("FAIL fast_word: got %h (%0d bits), want 8001 (16 bits)", rx_b, nbits);
    end
    n_checks++;
    if (busy_cyc !== 34) begin
      n_fail++;
      $display("FAIL fast_busy_len: got %0d, want 34", busy_cyc);
    end
    n_checks++;
    if (fsync_cyc !== 33) begin
      n_fail++;
      $display("FAIL fast_fsync_len: got %0d, want 33", fsync_cyc);
    end
    n_checks++;
    if (toggles !== 32) begin
      n_fail++;
      $display("FAIL fast_sclk_toggles: got %0d, want 32", toggles);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_reset_abort();
    test_single();
    test_held_start();
    test_fast();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL final_pending: got %0d words outstanding, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
